// File: rtl/uart_rx_loader.sv
// uart_rx_loader
//   UART 8N1 receiver that reports every correctly framed byte and packs
//   each group of four bytes (little-endian) into a 32-bit word, which is
//   written to a word-addressed program-memory write port.
//
// Parameters
//   CLK_HZ    system clock frequency in Hz
//   BAUDRATE  serial bit rate
//   AW        memory word-address width (address wraps at 2^AW)
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   RX         serial input, idle high, asynchronous to clk
//   load_en    enables memory writes for completed words
//   rx_byte    last correctly framed byte
//   rx_valid   one-cycle pulse, rx_byte is new
//   frame_err  one-cycle pulse, stop bit sampled low
//   mem_we     one-cycle write strobe
//   mem_a      word address of the write
//   mem_wd     write data
module uart_rx_loader #(
  parameter int CLK_HZ   = 25_000_000,
  parameter int BAUDRATE = 9600,
  parameter int AW       = 13
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          RX,
  input  logic          load_en,
  output logic [7:0]    rx_byte,
  output logic          rx_valid,
  output logic          frame_err,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [31:0]   mem_wd
);

  localparam int CPB  = CLK_HZ / BAUDRATE;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  // Receiver state
  logic          rx_s1, rxs;
  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bidx, bidx_n;
  logic [7:0]    shreg, shreg_n;
  logic [7:0]    byte_n;
  logic          valid_n, ferr_n;

  // Word packing state
  logic [1:0]    lane;
  logic [31:0]   word_buf;
  logic [AW-1:0] addr;

  // Two-flop synchroniser, idles high so reset does not look like a start bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      rx_s1 <= RX;
      rxs   <= rx_s1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bidx      <= '0;
      shreg     <= '0;
      rx_byte   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bidx      <= bidx_n;
      shreg     <= shreg_n;
      rx_byte   <= byte_n;
      rx_valid  <= valid_n;
      frame_err <= ferr_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    bidx_n  = bidx;
    shreg_n = shreg;
    byte_n  = rx_byte;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rxs) begin
          // The falling edge of rxs was one cycle ago, so the half-bit
          // count starts at 1 to keep the sample HALF cycles after it.
          state_n = START;
          cnt_n   = CW'(1);
          bidx_n  = '0;
        end
      end
      START: begin
        if (cnt >= CW'(HALF - 1)) begin
          cnt_n   = '0;
          state_n = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == CW'(CPB - 1)) begin
          cnt_n         = '0;
          shreg_n[bidx] = rxs;
          if (bidx == 3'd7) begin
            state_n = STOP;
          end else begin
            bidx_n = bidx + 3'd1;
          end
        end
      end
      STOP: begin
        if (cnt == CW'(CPB - 1)) begin
          cnt_n = '0;
          if (rxs) begin
            byte_n  = shreg;
            valid_n = 1'b1;
            state_n = IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = BREAK;
          end
        end
      end
      BREAK: begin
        cnt_n = '0;
        if (rxs) state_n = IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  // Packing runs off the registered rx_valid pulse, which places mem_we
  // exactly one cycle after the pulse of the fourth byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane     <= '0;
      word_buf <= '0;
      addr     <= '0;
      mem_we   <= 1'b0;
      mem_a    <= '0;
      mem_wd   <= '0;
    end else begin
      mem_we <= 1'b0;
      if (rx_valid) begin
        word_buf[{lane, 3'b000} +: 8] <= rx_byte;
        lane                          <= lane + 2'd1;
        if (lane == 2'd3 && load_en) begin
          mem_we <= 1'b1;
          mem_wd <= {rx_byte, word_buf[23:0]};
          mem_a  <= addr;
          addr   <= addr + AW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_loader.sv
// tb_uart_rx_loader
//   Directed bench for uart_rx_loader at CLK_HZ=16, BAUDRATE=1 (16 clocks
//   per bit) with AW=2 so that the address wrap is reachable.
module tb_uart_rx_loader;

  localparam int CPB = 16;
  // RX falling edge -> rxs (2) -> start sample (8) -> 8 data + stop (9*16)
  localparam int FRAME_LAT = 2 + 8 + 9 * CPB;

  logic        clk = 1'b0;
  logic        rst;
  logic        RX;
  logic        load_en;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        frame_err;
  logic        mem_we;
  logic [1:0]  mem_a;
  logic [31:0] mem_wd;

  uart_rx_loader #(
    .CLK_HZ  (16),
    .BAUDRATE(1),
    .AW      (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .RX       (RX),
    .load_en  (load_en),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .mem_we   (mem_we),
    .mem_a    (mem_a),
    .mem_wd   (mem_wd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Passive record of DUT output pulses, sampled on the falling edge
  int          n_valid = 0, n_ferr = 0, n_we = 0;
  int          v_cyc = 0, f_cyc = 0, we_cyc = 0;
  logic [7:0]  v_byte = '0;
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];

  always @(negedge clk) begin
    if (rx_valid) begin
      n_valid = n_valid + 1;
      v_cyc   = cyc;
      v_byte  = rx_byte;
    end
    if (frame_err) begin
      n_ferr = n_ferr + 1;
      f_cyc  = cyc;
    end
    if (mem_we) begin
      n_we   = n_we + 1;
      we_cyc = cyc;
      wa_q.push_back(32'(mem_a));
      wd_q.push_back(mem_wd);
    end
  end

  int vectors     = 0;
  int miscompares = 0;
  int t0          = 0;
  int bv, bf, bw;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors = vectors + 1;
    assert (obs === exp) else begin
      miscompares = miscompares + 1;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input int idx, input logic [31:0] a, input logic [31:0] d);
    if (idx < wa_q.size()) begin
      chk({tag, "_addr"}, wa_q[idx], a);
      chk({tag, "_data"}, wd_q[idx], d);
    end else begin
      chk({tag, "_present"}, 32'(wa_q.size()), 32'(idx + 1));
    end
  endtask

  task automatic mark();
    bv = n_valid;
    bf = n_ferr;
    bw = n_we;
  endtask

  task automatic do_reset();
    #3 rst = 1'b0;
    RX = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One frame; the line is left at the stop-bit level on return
  task automatic send(input logic [7:0] b, input logic stop);
    @(posedge clk);
    #1 RX = 1'b0;
    t0 = cyc;
    repeat (CPB) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    RX = stop;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send(w[8*i +: 8], 1'b1);
  endtask

  initial begin
    rst     = 1'b1;
    RX      = 1'b1;
    load_en = 1'b1;
    #2;
    do_reset();

    // Reset state
    chk("rst_rx_byte", 32'(rx_byte), 32'h0);
    chk("rst_rx_valid", 32'(rx_valid), 32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_a", 32'(mem_a), 32'h0);
    chk("rst_mem_wd", mem_wd, 32'h0);

    // Single byte, then complete the word to expose the lane it used
    mark();
    send(8'hA5, 1'b1);
    chk("a5_valid_cnt", 32'(n_valid - bv), 32'd1);
    chk("a5_byte", 32'(v_byte), 32'hA5);
    chk("a5_latency", 32'(v_cyc - t0), 32'(FRAME_LAT));
    chk("a5_no_we", 32'(n_we - bw), 32'd0);
    send(8'h01, 1'b1);
    send(8'h02, 1'b1);
    send(8'h03, 1'b1);
    chk("a5_word_we_cnt", 32'(n_we - bw), 32'd1);
    chk_wr("a5_word", 0, 32'd0, 32'h030201A5);
    chk("we_after_valid", 32'(we_cyc - v_cyc), 32'd1);

    // Word writes and address wrap at AW=2
    do_reset();
    mark();
    send_word(32'h12345678);
    chk("w0_we_cnt", 32'(n_we - bw), 32'd1);
    chk_wr("w0", 1, 32'd0, 32'h12345678);
    send_word(32'hDEADBEEF);
    chk_wr("w1", 2, 32'd1, 32'hDEADBEEF);
    send_word(32'h04030201);
    send_word(32'h08070605);
    send_word(32'h0C0B0A09);
    chk("wrap_we_cnt", 32'(n_we - bw), 32'd5);
    chk("wrap_valid_cnt", 32'(n_valid - bv), 32'd20);
    chk_wr("w2", 3, 32'd2, 32'h04030201);
    chk_wr("w3", 4, 32'd3, 32'h08070605);
    chk_wr("w4_wrap", 5, 32'd0, 32'h0C0B0A09);

    // load_en low: bytes reported, no write, address held
    load_en = 1'b0;
    mark();
    send_word(32'hF3F2F1F0);
    chk("noload_valid_cnt", 32'(n_valid - bv), 32'd4);
    chk("noload_we_cnt", 32'(n_we - bw), 32'd0);
    load_en = 1'b1;
    send_word(32'h88776655);
    chk("reload_we_cnt", 32'(n_we - bw), 32'd1);
    chk_wr("reload", 6, 32'd1, 32'h88776655);

    // Frame error followed by a held-low line
    mark();
    send(8'h3C, 1'b0);
    repeat (40) @(posedge clk);
    #1 RX = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("ferr_cnt", 32'(n_ferr - bf), 32'd1);
    chk("ferr_latency", 32'(f_cyc - t0), 32'(FRAME_LAT));
    chk("ferr_no_valid", 32'(n_valid - bv), 32'd0);
    send_word(32'h44332211);
    chk("ferr_valid_cnt", 32'(n_valid - bv), 32'd4);
    chk_wr("ferr_next_lane0", 7, 32'd2, 32'h44332211);

    // Short glitch in idle
    mark();
    @(posedge clk);
    #1 RX = 1'b0;
    repeat (4) @(posedge clk);
    #1 RX = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("glitch_valid", 32'(n_valid - bv), 32'd0);
    chk("glitch_ferr", 32'(n_ferr - bf), 32'd0);
    chk("glitch_we", 32'(n_we - bw), 32'd0);
    send(8'h96, 1'b1);
    chk("glitch_next_byte", 32'(v_byte), 32'h96);

    // Asynchronous reset in the middle of data bit 4 of 0x81
    chk("pre_rst_mem_a", 32'(mem_a), 32'd2);
    @(posedge clk);
    #1 RX = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      #1 RX = (i == 0);
      repeat (CPB) @(posedge clk);
    end
    #1 RX = 1'b0;
    repeat (8) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("arst_rx_byte", 32'(rx_byte), 32'h0);
    chk("arst_rx_valid", 32'(rx_valid), 32'h0);
    chk("arst_frame_err", 32'(frame_err), 32'h0);
    chk("arst_mem_we", 32'(mem_we), 32'h0);
    chk("arst_mem_a", 32'(mem_a), 32'h0);
    chk("arst_mem_wd", mem_wd, 32'h0);
    RX = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    mark();
    send(8'h81, 1'b1);
    chk("arst_after_byte", 32'(v_byte), 32'h81);
    send(8'h5A, 1'b1);
    send(8'hC3, 1'b1);
    send(8'h7E, 1'b1);
    chk("arst_after_valid_cnt", 32'(n_valid - bv), 32'd4);
    chk_wr("arst_after_word", 8, 32'd0, 32'h7EC35A81);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
